// File: rtl/mem_burst_scheduler_pkg.sv
// Shared types and defaults for the memory burst scheduler: core count,
// credit depth, the FSM state encoding and the burst request header.
package mem_burst_scheduler_pkg;

   localparam int NUM_OF_CORES    = 4;
   localparam int MAX_OUTSTANDING = 4;
   localparam int LEN_W           = 8;
   localparam int CORE_ID_W       = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } sched_state_e;

   typedef struct packed {
      logic                 vld;
      logic [CORE_ID_W-1:0] core_id;
      logic [LEN_W-1:0]     access_length;
   } request_t;

endpackage

// File: rtl/mem_burst_scheduler_rr_pick.sv
// Combinational rotate-priority picker: the first set request at or above ptr,
// wrapping at NUM_REQ, reported both one-hot and as an index.
module mem_burst_scheduler_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
            any = 1'b1;
            gnt[(int'(ptr) + k) % NUM_REQ] = 1'b1;
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/mem_burst_scheduler.sv
// Round-robin burst scheduler sharing one memory request port between cores,
// holding each grant for a whole burst and limiting bursts in flight with credits.
module mem_burst_scheduler #(
   parameter int NUM_OF_CORES    = mem_burst_scheduler_pkg::NUM_OF_CORES,
   parameter int LEN_W           = mem_burst_scheduler_pkg::LEN_W,
   parameter int MAX_OUTSTANDING = mem_burst_scheduler_pkg::MAX_OUTSTANDING,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_OF_CORES-1:0]            req_vld,
   input  logic [NUM_OF_CORES-1:0][LEN_W-1:0] req_len,
   output logic [NUM_OF_CORES-1:0]            req_rdy,
   output logic [NUM_OF_CORES-1:0]            grant,
   output logic                               mem_vld,
   input  logic                               mem_rdy,
   output logic                               mem_last,
   input  logic                               rsp_vld,
   input  logic [3:0]                         rsp_core_id,
   input  logic                               rsp_last,
   output logic                               busy
);

   import mem_burst_scheduler_pkg::*;

   // rsp_core_id is 4 bits wide, so NUM_OF_CORES must not exceed 16.
   localparam int IDX_W = (NUM_OF_CORES > 1) ? $clog2(NUM_OF_CORES) : 1;

   sched_state_e state_q, state_d;
   logic [NUM_OF_CORES-1:0]            grant_q, grant_d;
   logic [NUM_OF_CORES-1:0]            req_rdy_q, req_rdy_d;
   logic [IDX_W-1:0]                   gidx_q, gidx_d;
   logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0]                   beat_cnt_q, beat_cnt_d;
   logic [NUM_OF_CORES-1:0][CNT_W-1:0] credit_q, credit_d;

   logic [NUM_OF_CORES-1:0] eligible;
   logic [NUM_OF_CORES-1:0] pick_oh;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_any;
   logic [NUM_OF_CORES-1:0] cred_inc, cred_dec;
   logic                    beat_acc, burst_done;
   request_t                hdr;

   always_comb begin
      for (int i = 0; i < NUM_OF_CORES; i++) begin
         eligible[i] = req_vld[i] && (credit_q[i] < CNT_W'(MAX_OUTSTANDING));
      end
   end

   mem_burst_scheduler_rr_pick #(
      .NUM_REQ (NUM_OF_CORES),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req (eligible),
      .ptr (rr_ptr_q),
      .gnt (pick_oh),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      hdr.vld           = pick_any;
      hdr.core_id       = CORE_ID_W'(pick_idx);
      hdr.access_length = req_len[pick_idx];
   end

   assign mem_vld    = (state_q == BURST);
   assign mem_last   = mem_vld && (beat_cnt_q == '0);
   assign beat_acc   = mem_vld && mem_rdy;
   assign burst_done = beat_acc && mem_last;
   assign grant      = grant_q;
   assign req_rdy    = req_rdy_q;
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      req_rdy_d  = '0;
      case (state_q)
         IDLE: begin
            if (hdr.vld) begin
               state_d    = BURST;
               grant_d    = pick_oh;
               gidx_d     = IDX_W'(hdr.core_id);
               req_rdy_d  = pick_oh;
               // A zero length still moves one beat.
               beat_cnt_d = (hdr.access_length == '0) ? '0 : hdr.access_length - 1'b1;
            end
         end
         BURST: begin
            if (beat_acc) begin
               if (beat_cnt_q == '0) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = (gidx_q == IDX_W'(NUM_OF_CORES - 1)) ? '0 : gidx_q + 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Matching increment and decrement on one core cancel; a return to an
   // empty counter is dropped rather than wrapping.
   always_comb begin
      credit_d = credit_q;
      for (int i = 0; i < NUM_OF_CORES; i++) begin
         cred_inc[i] = burst_done && (gidx_q == IDX_W'(i));
         cred_dec[i] = rsp_vld && rsp_last && (rsp_core_id == 4'(i)) && (credit_q[i] != '0);
         if (cred_inc[i] && !cred_dec[i]) begin
            credit_d[i] = credit_q[i] + 1'b1;
         end else if (!cred_inc[i] && cred_dec[i]) begin
            credit_d[i] = credit_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         req_rdy_q  <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         credit_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         req_rdy_q  <= req_rdy_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         credit_q   <= credit_d;
      end
   end

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!reset)
      $onehot0(grant_q)) else $error("grant not onehot0");

   a_grant_stable : assert property (@(posedge clk) disable iff (!reset)
      (mem_vld && !mem_rdy) |=> $stable(grant_q)) else $error("grant changed under backpressure");

   for (genvar g = 0; g < NUM_OF_CORES; g++) begin : g_credit_chk
      a_credit_max : assert property (@(posedge clk) disable iff (!reset)
         credit_q[g] <= CNT_W'(MAX_OUTSTANDING)) else $error("credit overflow core %0d", g);
      a_credit_underflow : assert property (@(posedge clk) disable iff (!reset)
         (rsp_vld && rsp_last && rsp_core_id == 4'(g)) |-> (credit_q[g] != '0))
         else $error("credit return to empty counter core %0d", g);
   end

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Directed bench for mem_burst_scheduler: one task per scenario, each with
// hand-derived expected values checked inline.
module tb_mem_burst_scheduler;

   localparam int N  = 4;
   localparam int LW = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N-1:0]         req_vld;
   logic [N-1:0][LW-1:0] req_len;
   logic [N-1:0]         req_rdy;
   logic [N-1:0]         grant;
   logic                 mem_vld, mem_rdy, mem_last;
   logic                 rsp_vld, rsp_last, busy;
   logic [3:0]           rsp_core_id;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_burst_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .req_vld     (req_vld),
      .req_len     (req_len),
      .req_rdy     (req_rdy),
      .grant       (grant),
      .mem_vld     (mem_vld),
      .mem_rdy     (mem_rdy),
      .mem_last    (mem_last),
      .rsp_vld     (rsp_vld),
      .rsp_core_id (rsp_core_id),
      .rsp_last    (rsp_last),
      .busy        (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_vld     = '0;
      req_len     = '0;
      mem_rdy     = 1'b1;
      rsp_vld     = 1'b0;
      rsp_last    = 1'b0;
      rsp_core_id = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      req_vld = '1;
      for (int i = 0; i < N; i++) req_len[i] = 8'd3;
      tick();
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_req_rdy got=%b exp=0000", req_rdy); end
      checks++; if ({mem_vld, mem_last, busy} !== 3'b000) begin failures++; $display("FAIL reset_vld_last_busy got=%b exp=000", {mem_vld, mem_last, busy}); end
      checks++; if (dut.credit_q !== '0) begin failures++; $display("FAIL reset_credits got=%h exp=0", dut.credit_q); end
      idle_inputs();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_burst();
      do_reset();
      req_vld = 4'b0001; req_len[0] = 8'd3;
      tick();
      checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL single_req_rdy got=%b exp=0001", req_rdy); end
      checks++; if (grant !== 4'b0001 || mem_vld !== 1'b1 || mem_last !== 1'b0) begin failures++; $display("FAIL single_beat1 got=%b/%b/%b exp=0001/1/0", grant, mem_vld, mem_last); end
      req_vld = '0;
      tick();
      checks++; if (req_rdy !== 4'b0000 || mem_vld !== 1'b1 || mem_last !== 1'b0) begin failures++; $display("FAIL single_beat2 got=%b/%b/%b exp=0000/1/0", req_rdy, mem_vld, mem_last); end
      tick();
      checks++; if (grant !== 4'b0001 || mem_last !== 1'b1) begin failures++; $display("FAIL single_beat3_last got=%b/%b exp=0001/1", grant, mem_last); end
      tick();
      checks++; if (mem_vld !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_done got=%b/%b/%b exp=0/0000/0", mem_vld, grant, busy); end
      checks++; if (dut.credit_q[0] !== 3'd1) begin failures++; $display("FAIL single_credit0 got=%0d exp=1", dut.credit_q[0]); end
   endtask

   task automatic test_len_zero();
      do_reset();
      req_vld = 4'b0010; req_len[1] = 8'd0;
      tick();
      checks++; if (grant !== 4'b0010 || mem_last !== 1'b1) begin failures++; $display("FAIL len0_single_beat got=%b/%b exp=0010/1", grant, mem_last); end
      req_vld = '0;
      tick();
      checks++; if (mem_vld !== 1'b0 || dut.credit_q[1] !== 3'd1) begin failures++; $display("FAIL len0_done got=%b/%0d exp=0/1", mem_vld, dut.credit_q[1]); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp;
      do_reset();
      req_vld = 4'b1111;
      for (int i = 0; i < N; i++) req_len[i] = 8'd1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         rsp_vld = 1'b0; rsp_last = 1'b0;
         exp = '0;
         if (k % 2 == 1) exp[((k - 1) / 2) % N] = 1'b1;
         checks++; if (grant !== exp) begin failures++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", k, grant, exp); end
         if (k % 2 == 0) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_bubble cycle=%0d busy=%b exp=0", k, busy); end
            rsp_vld = 1'b1; rsp_last = 1'b1; rsp_core_id = 4'(((k - 2) / 2) % N);
         end
         if (k == 10) req_vld = '0;
      end
      tick();
      rsp_vld = 1'b0; rsp_last = 1'b0;
      checks++; if (dut.credit_q !== '0 || grant !== 4'b0000) begin failures++; $display("FAIL rr_credits_returned got=%h/%b exp=0/0000", dut.credit_q, grant); end
   endtask

   task automatic test_backpressure();
      int beats = 0;
      int lasts = 0;
      do_reset();
      req_vld = 4'b0100; req_len[2] = 8'd4;
      tick();
      req_vld = '0;
      for (int c = 0; c < 20; c++) begin
         mem_rdy = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
         if (!mem_vld) break;
         checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL bp_grant_held cycle=%0d got=%b exp=0100", c, grant); end
         if (mem_rdy && mem_last) begin
            lasts++;
            checks++; if (beats != 3) begin failures++; $display("FAIL bp_last_position got=beat%0d exp=beat4", beats + 1); end
         end
         if (mem_rdy) beats++;
         tick();
      end
      mem_rdy = 1'b1;
      checks++; if (beats != 4 || lasts != 1) begin failures++; $display("FAIL bp_beat_count got=%0d/%0d exp=4/1", beats, lasts); end
      checks++; if (dut.credit_q[2] !== 3'd1 || grant !== 4'b0000) begin failures++; $display("FAIL bp_done got=%0d/%b exp=1/0000", dut.credit_q[2], grant); end
   endtask

   task automatic test_credit_limit();
      logic [N-1:0] exp;
      do_reset();
      req_vld = 4'b0010; req_len[1] = 8'd1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp = (k % 2 == 1 && k <= 7) ? 4'b0010 : 4'b0000;
         checks++; if (grant !== exp || req_rdy !== exp) begin failures++; $display("FAIL credit_grant cycle=%0d got=%b/%b exp=%b", k, grant, req_rdy, exp); end
      end
      checks++; if (dut.credit_q[1] !== 3'd4) begin failures++; $display("FAIL credit_full got=%0d exp=4", dut.credit_q[1]); end
      rsp_vld = 1'b1; rsp_last = 1'b1; rsp_core_id = 4'd1;
      tick();
      rsp_vld = 1'b0; rsp_last = 1'b0;
      checks++; if (grant !== 4'b0000 || dut.credit_q[1] !== 3'd3) begin failures++; $display("FAIL credit_return got=%b/%0d exp=0000/3", grant, dut.credit_q[1]); end
      tick();
      checks++; if (grant !== 4'b0010 || req_rdy !== 4'b0010) begin failures++; $display("FAIL credit_regrant got=%b/%b exp=0010", grant, req_rdy); end
      req_vld = '0;
      tick();
   endtask

   task automatic test_simul_credit();
      do_reset();
      req_vld = 4'b1000; req_len[3] = 8'd1;
      tick();
      tick();
      checks++; if (dut.credit_q[3] !== 3'd1) begin failures++; $display("FAIL simul_first_credit got=%0d exp=1", dut.credit_q[3]); end
      tick();
      checks++; if (grant !== 4'b1000 || mem_last !== 1'b1) begin failures++; $display("FAIL simul_second_burst got=%b/%b exp=1000/1", grant, mem_last); end
      req_vld = '0;
      rsp_vld = 1'b1; rsp_last = 1'b1; rsp_core_id = 4'd3;
      tick();
      checks++; if (dut.credit_q[3] !== 3'd1 || grant !== 4'b0000) begin failures++; $display("FAIL simul_inc_dec got=%0d/%b exp=1/0000", dut.credit_q[3], grant); end
      rsp_core_id = 4'd7;
      tick();
      checks++; if (dut.credit_q !== {3'd1, 3'd0, 3'd0, 3'd0}) begin failures++; $display("FAIL simul_invalid_id got=%h exp=%h", dut.credit_q, {3'd1, 3'd0, 3'd0, 3'd0}); end
      rsp_core_id = 4'd3; rsp_last = 1'b0;
      tick();
      checks++; if (dut.credit_q[3] !== 3'd1) begin failures++; $display("FAIL simul_not_last got=%0d exp=1", dut.credit_q[3]); end
      rsp_last = 1'b1;
      tick();
      rsp_vld = 1'b0; rsp_last = 1'b0;
      checks++; if (dut.credit_q[3] !== 3'd0) begin failures++; $display("FAIL simul_return got=%0d exp=0", dut.credit_q[3]); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_vld = 4'b0001; req_len[0] = 8'd1;
      tick();
      req_vld = 4'b0100; req_len[2] = 8'd5;
      tick();
      tick();
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rst_mid_grant got=%b exp=0100", grant); end
      tick();
      #1;
      reset = 1'b0;
      #1;
      checks++; if (grant !== 4'b0000 || mem_vld !== 1'b0 || busy !== 1'b0 || mem_last !== 1'b0) begin failures++; $display("FAIL rst_mid_clear got=%b/%b/%b/%b exp=0000/0/0/0", grant, mem_vld, busy, mem_last); end
      checks++; if (dut.credit_q !== '0) begin failures++; $display("FAIL rst_mid_credits got=%h exp=0", dut.credit_q); end
      req_vld = 4'b1111;
      for (int i = 0; i < N; i++) req_len[i] = 8'd1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++; if (grant !== 4'b0001 || req_rdy !== 4'b0001) begin failures++; $display("FAIL rst_mid_first_grant got=%b/%b exp=0001", grant, req_rdy); end
      idle_inputs();
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      reset = 1'b0;
      test_reset();
      test_single_burst();
      test_len_zero();
      test_round_robin();
      test_backpressure();
      test_credit_limit();
      test_simul_credit();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
